cpu_mem_bridge: RTL

Memory-side bridge directly downstream of the 16-bit pipelined CPU. It decodes the CPU's single-cycle read/write port into an on-chip synchronous RAM and an 8-bit-addressed I/O window. I/O writes are posted through a small FIFO to a slower valid/ready peripheral bus, so the CPU, which has no stall input, never waits. It returns read data with the fixed one-cycle latency the CPU expects.

---
 rtl/membus_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 58 +++++
 rtl/cpu_mem_bridge.sv | 134 +++++++++++++
 3 files changed

// File: rtl/membus_pkg.sv
// Shared definitions for the CPU memory bridge: I/O window defaults, read-select
// encoding and the posted-write FIFO entry layout.
package membus_pkg;

  localparam logic [7:0]  IO_BASE_DEFAULT = 8'hFF;
  localparam logic [7:0]  STATUS_OFFSET   = 8'hFF;
  localparam int unsigned WF_ENTRY_W      = 24;

  typedef enum logic [1:0] {
    RSEL_RAM  = 2'd0,
    RSEL_IO   = 2'd1,
    RSEL_STAT = 2'd2
  } rsel_e;

  // Entry layout is {addr[7:0], data[15:0]}.
  function automatic logic [WF_ENTRY_W-1:0] wf_pack(input logic [7:0]  addr,
                                                    input logic [15:0] data);
    return {addr, data};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and a level counter; a push while
// full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   LVL_ONE = (AW+1)'(1);
  localparam logic [AW:0]   LVL_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == LVL_MAX);
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rptr];

  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/cpu_mem_bridge.sv
// CPU-side bridge: RAM pass-through, I/O window with posted-write FIFO, one-cycle
// read mux. Define CPU_MEM_BRIDGE_STATUS_EN for the status/overflow register.
module cpu_mem_bridge
  import membus_pkg::*;
#(
  parameter logic [7:0]  IO_BASE  = IO_BASE_DEFAULT,
  parameter int unsigned WF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_raddr,
  input  logic        cpu_rd,
  output logic [15:0] cpu_rdata,
  input  logic [15:0] cpu_waddr,
  input  logic [15:0] cpu_wdata,
  input  logic        cpu_wr,
  output logic [15:0] ram_raddr,
  input  logic [15:0] ram_rdata,
  output logic [15:0] ram_waddr,
  output logic [15:0] ram_wdata,
  output logic        ram_we,
  output logic [7:0]  io_raddr,
  output logic        io_rd,
  input  logic [15:0] io_rdata,
  output logic        io_wvalid,
  output logic [7:0]  io_waddr,
  output logic [15:0] io_wdata,
  input  logic        io_wready,
  output logic        io_busy
);

  localparam int unsigned LW = $clog2(WF_DEPTH) + 1;

  logic                  w_rd_win;
  logic                  w_wr_win;
  logic                  w_rd_stat;
  logic                  w_wr_stat;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [LW-1:0]         w_level;
  logic [WF_ENTRY_W-1:0] w_head;
  logic [15:0]           w_stat_word;
  rsel_e                 r_rsel;

  assign ram_raddr = cpu_raddr;
  assign ram_waddr = cpu_waddr;
  assign ram_wdata = cpu_wdata;
  assign io_raddr  = cpu_raddr[7:0];

  assign w_rd_win  = (cpu_raddr[15:8] == IO_BASE);
  assign w_wr_win  = (cpu_waddr[15:8] == IO_BASE);

`ifdef CPU_MEM_BRIDGE_STATUS_EN
  assign w_rd_stat = w_rd_win & (cpu_raddr[7:0] == STATUS_OFFSET);
  assign w_wr_stat = w_wr_win & (cpu_waddr[7:0] == STATUS_OFFSET);
`else
  assign w_rd_stat = 1'b0;
  assign w_wr_stat = 1'b0;
`endif

  assign io_rd     = cpu_rd & w_rd_win & ~w_rd_stat;
  assign ram_we    = cpu_wr & ~w_wr_win;
  assign w_push    = cpu_wr & w_wr_win & ~w_wr_stat;
  assign w_pop     = io_wvalid & io_wready;

  sync_fifo #(
    .WIDTH (WF_ENTRY_W),
    .DEPTH (WF_DEPTH)
  ) u_wfifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (wf_pack(cpu_waddr[7:0], cpu_wdata)),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign io_wvalid = ~w_empty;
  assign io_busy   = ~w_empty;
  assign io_waddr  = w_head[23:16];
  assign io_wdata  = w_head[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsel <= RSEL_RAM;
    end else if (cpu_rd) begin
      r_rsel <= w_rd_stat ? RSEL_STAT : (w_rd_win ? RSEL_IO : RSEL_RAM);
    end
  end

  always_comb begin
    cpu_rdata = ram_rdata;
    case (r_rsel)
      RSEL_IO:   cpu_rdata = io_rdata;
      RSEL_STAT: cpu_rdata = w_stat_word;
      default:   cpu_rdata = ram_rdata;
    endcase
  end

`ifdef CPU_MEM_BRIDGE_STATUS_EN
  logic [7:0]  r_ovf;
  logic [15:0] r_stat;
  logic        w_drop;

  assign w_drop      = w_push & w_full & ~w_pop;
  assign w_stat_word = r_stat;

  // A clear coinciding with a drop counts that drop, so ovf lands on 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf  <= '0;
      r_stat <= '0;
    end else begin
      if (w_wr_stat)
        r_ovf <= w_drop ? 8'd1 : 8'd0;
      else if (w_drop && (r_ovf != 8'hFF))
        r_ovf <= r_ovf + 8'd1;
      if (cpu_rd && w_rd_stat)
        r_stat <= {r_ovf, 3'b000, 5'(w_level)};
    end
  end
`else
  logic w_unused_stat;

  assign w_stat_word   = '0;
  assign w_unused_stat = ^{w_full, w_level};
`endif

endmodule
